// File: rtl/ysyx_22050612_pkg.sv
// Shared fetch-queue types and constants.
package ysyx_22050612_pkg;

   // Fetch FSM: at most one memory request in flight at any time.
   typedef enum logic [1:0] {
      IDLE = 2'd0,  // queue has no room reserved, no request
      REQ  = 2'd1,  // request presented to memory
      WAIT = 2'd2,  // request accepted, waiting for its response
      DROP = 2'd3   // response of a redirected-away request must be discarded
   } fq_state_e;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22050612_fifo.sv
// Power-of-two circular buffer with occupancy count and single-cycle flush.
module ysyx_22050612_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wptr;
   logic [AW-1:0]               rptr;

   // Pointers wrap naturally since DEPTH is a power of two; flush wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written so no reset.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];

endmodule

// File: rtl/ysyx_22050612_fetch_queue.sv
// Instruction fetch sequencer feeding a small in-order instruction queue.
module ysyx_22050612_fetch_queue
   import ysyx_22050612_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [XLEN-1:0]           mem_req_addr,
   input  logic                      mem_rsp_valid,
   input  logic [ILEN-1:0]           mem_rsp_data,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic                      inst_valid,
   input  logic                      inst_ready,
   output logic [ILEN-1:0]           inst,
   output logic [XLEN-1:0]           inst_pc,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int CW = $clog2(DEPTH) + 1;

   fq_state_e       state, state_nxt;
   logic [XLEN-1:0] fetch_pc;
   logic            hs, push, pop, room;
   logic [CW-1:0]   count_nxt;

   // A redirect flushes the queue, so it overrides both push and pop.
   assign hs   = mem_req_valid && mem_req_ready;
   assign push = (state == WAIT) && mem_rsp_valid && !redirect_valid;
   assign pop  = inst_valid && inst_ready && !redirect_valid;

   // Occupancy after this edge; a request is only launched with room left.
   always_comb begin
      count_nxt = count;
      if (redirect_valid)   count_nxt = '0;
      else if (push && !pop) count_nxt = count + 1'b1;
      else if (pop && !push) count_nxt = count - 1'b1;
   end
   assign room = (count_nxt < CW'(DEPTH));

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (redirect_valid || room) state_nxt = REQ;
         REQ: begin
            if (redirect_valid) state_nxt = hs ? DROP : REQ;
            else if (hs)        state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid)       state_nxt = (redirect_valid || room) ? REQ : IDLE;
            else if (redirect_valid) state_nxt = DROP;
         end
         // A response coinciding with a redirect retires the stale fetch,
         // so waiting for another one would stall forever.
         DROP: if (mem_rsp_valid) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: request is presented only while in REQ.
   always_comb begin
      mem_req_valid = (state == REQ);
      mem_req_addr  = fetch_pc;
   end

   // Fetch PC advances per accepted instruction, or jumps on redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 fetch_pc <= RESET_PC;
      else if (redirect_valid) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (push)           fetch_pc <= fetch_pc + XLEN'(4);
   end

   ysyx_22050612_fifo #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata ({fetch_pc, mem_rsp_data}),
      .rdata ({inst_pc, inst}),
      .count (count)
   );

   assign inst_valid = (count != '0);

endmodule

// File: tb/tb_ysyx_22050612_fetch_queue.sv
// Directed bench for the fetch queue with a one-outstanding memory responder.
module tb_ysyx_22050612_fetch_queue;
   localparam int XLEN = 64, ILEN = 32, DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            mem_req_valid, mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_rsp_valid;
   logic [ILEN-1:0] mem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid, inst_ready;
   logic [ILEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic [2:0]      count;

   int checks = 0, failures = 0;
   int rsp_lat = 0;
   bit rsp_kill = 1'b0;
   logic [63:0] req_log[$];
   logic [63:0] exp4[4];
   int n0;

   always #5 clk = ~clk;

   ysyx_22050612_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .count(count)
   );

   function automatic logic [31:0] inst_of(logic [63:0] a);
      return {a[15:0] ^ 16'h5A5A, 16'h0013};
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle past the responder's updates.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Memory model: logs accepted addresses, answers after rsp_lat extra cycles.
   initial begin
      logic [63:0] a;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (mem_req_valid && mem_req_ready && !rst) begin
            a = mem_req_addr;
            req_log.push_back(a);
            @(posedge clk);
            repeat (rsp_lat) @(posedge clk);
            #1;
            if (!rsp_kill) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = inst_of(a);
            end
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
         end
      end
   end

   initial begin
      rst = 1'b1; mem_req_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; inst_ready = 1'b0;
      exp4 = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};

      // Reset state, then first request one edge after release.
      repeat (2) @(posedge clk);
      #2;
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_count", count, 0);
      rst = 1'b0;
      #1;
      chk("idle_after_rst", mem_req_valid, 0);
      step();
      chk("first_req_valid", mem_req_valid, 1);
      chk("first_req_addr", mem_req_addr, 64'h8000_0000);

      // Fill with no consumer: four sequential fetches, then stop.
      for (int n = 0; n < 40 && !(count == 4 && !mem_req_valid); n++) step();
      chk("fill_count", count, 4);
      chk("fill_req_valid", mem_req_valid, 0);
      chk("fill_nreq", req_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("fill_addr", req_log[i], exp4[i]);
      chk("fill_head_pc", inst_pc, 64'h8000_0000);
      chk("fill_head_inst", inst, inst_of(64'h8000_0000));
      repeat (3) step();
      chk("full_no_req", req_log.size(), 4);

      // One pop from full: exactly one refill, order preserved.
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("pop_count", count, 3);
      chk("pop_head_pc", inst_pc, 64'h8000_0004);
      for (int n = 0; n < 20 && !(count == 4 && !mem_req_valid); n++) step();
      chk("refill_count", count, 4);
      chk("refill_nreq", req_log.size(), 5);
      chk("refill_addr", req_log[4], 64'h8000_0010);
      for (int k = 0; k < 4; k++) begin
         chk("order_pc", inst_pc, 64'h8000_0004 + 64'(4 * k));
         inst_ready = 1'b1;
         step();
         inst_ready = 1'b0;
      end

      // Redirect while waiting: the stale response is dropped.
      for (int n = 0; n < 20 && !(count == 4 && !mem_req_valid); n++) step();
      rsp_lat = 2;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("pre_wait_req", mem_req_valid, 1);
      step();
      chk("in_wait", mem_req_valid, 0);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
      step();
      redirect_valid = 1'b0;
      chk("wredir_count", count, 0);
      chk("wredir_inst_valid", inst_valid, 0);
      chk("drop_no_req", mem_req_valid, 0);
      rsp_lat = 0;
      for (int n = 0; n < 10 && !mem_req_valid; n++) step();
      chk("drop_next_addr", mem_req_addr, 64'h8000_0100);
      chk("drop_no_push", count, 0);
      for (int n = 0; n < 10 && !inst_valid; n++) step();
      chk("drop_head_pc", inst_pc, 64'h8000_0100);
      chk("drop_head_inst", inst, inst_of(64'h8000_0100));

      // Redirect coinciding with a response and a pop.
      for (int n = 0; n < 20 && !(mem_rsp_valid && inst_valid); n++) step();
      chk("coin_setup", mem_rsp_valid && inst_valid, 1);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; inst_ready = 1'b1;
      step();
      redirect_valid = 1'b0; inst_ready = 1'b0;
      chk("coin_count", count, 0);
      chk("coin_req_valid", mem_req_valid, 1);
      chk("coin_addr", mem_req_addr, 64'h8000_2000);
      for (int n = 0; n < 10 && !inst_valid; n++) step();
      chk("coin_head_pc", inst_pc, 64'h8000_2000);

      // Stalled request redirected mid-stall: address switches, one accept.
      for (int n = 0; n < 10 && !mem_req_valid; n++) step();
      mem_req_ready = 1'b0;
      n0 = req_log.size();
      chk("stall_addr0", mem_req_addr, 64'h8000_2004);
      for (int c = 1; c <= 5; c++) begin
         if (c == 3) begin redirect_valid = 1'b1; redirect_pc = 64'h8000_3008; end
         step();
         redirect_valid = 1'b0;
         chk("stall_valid", mem_req_valid, 1);
         chk("stall_addr", mem_req_addr, (c < 3) ? 64'h8000_2004 : 64'h8000_3008);
      end
      chk("stall_flush", count, 0);
      mem_req_ready = 1'b1;
      step();
      rsp_lat = 3;
      chk("stall_one_accept", req_log.size(), n0 + 1);
      chk("stall_accept_addr", req_log[n0], 64'h8000_3008);

      // Asynchronous reset while waiting with two entries.
      for (int n = 0; n < 40 && !(count == 2 && !mem_req_valid); n++) step();
      chk("arst_setup_count", count, 2);
      rsp_kill = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("arst_req_valid", mem_req_valid, 0);
      chk("arst_inst_valid", inst_valid, 0);
      chk("arst_count", count, 0);
      repeat (6) @(posedge clk);
      #2;
      rsp_lat = 0; rsp_kill = 1'b0; rst = 1'b0;
      #1;
      chk("arst_idle", mem_req_valid, 0);
      step();
      chk("arst_restart_valid", mem_req_valid, 1);
      chk("arst_restart_addr", mem_req_addr, 64'h8000_0000);
      for (int n = 0; n < 10 && !inst_valid; n++) step();
      chk("arst_head_pc", inst_pc, 64'h8000_0000);

      // Unaligned redirect near the top of the address space; PC wraps.
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      redirect_valid = 1'b0;
      n0 = req_log.size();
      chk("wrap_flush", count, 0);
      for (int n = 0; n < 20 && req_log.size() < n0 + 2; n++) step();
      chk("wrap_nreq", req_log.size() >= n0 + 2, 1);
      if (req_log.size() >= n0 + 2) begin
         chk("wrap_addr0", req_log[n0], 64'hFFFF_FFFF_FFFF_FFFC);
         chk("wrap_addr1", req_log[n0 + 1], 64'h0);
      end
      chk("wrap_head_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
